// File: rtl/aes_state_fifo_if.sv
// Handshake bundle for the AES state FIFO: producer side, consumer side,
// flush control and occupancy. The producer/consumer drives the master view;
// the FIFO drives the slave view.
interface aes_state_fifo_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                                flush;
    logic                                in_valid;
    logic                                in_ready;
    logic [0:ROWS-1][0:COLS-1][7:0]      in_data;
    logic                                out_valid;
    logic                                out_ready;
    logic [0:ROWS-1][0:COLS-1][7:0]      out_data;
    logic [CNT_W-1:0]                    count;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );
endinterface

// File: rtl/aes_state_fifo.sv
// Zeroizing FIFO for AES state matrices. Every consumed slot is cleared on
// pop, and reset/flush clear all slots, so key-dependent state never lingers
// in storage after it has left the FIFO. Show-ahead head output, zero when
// empty. Pointers wrap explicitly so DEPTH need not be a power of two.
module aes_state_fifo #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    aes_state_fifo_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [0:ROWS-1][0:COLS-1][7:0] state_t;

    state_t             r_mem [0:DEPTH-1];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;

    // Explicit wrap at DEPTH-1 rather than relying on natural 2^n overflow.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    // in_ready depends only on registered occupancy and flush; no path from
    // out_ready, so a full FIFO never accepts even when being drained.
    assign w_in_ready  = !bus.flush && !w_full;
    assign w_out_valid = !bus.flush && !w_empty;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.count     = r_count;

    // Storage, pointers and occupancy; reset and flush both zeroize everything.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Push and pop never target the same slot: pop needs count>0,
            // push needs count<DEPTH, so wr_ptr != rd_ptr when both fire.
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_mem[r_rd_ptr] <= '0;
                r_rd_ptr        <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_state_fifo.sv
// Directed bench for aes_state_fifo (4x4 bytes, DEPTH=4) with a queue
// scoreboard: accepted states are queued, popped states are compared.
module tb_aes_state_fifo;
    typedef logic [0:3][0:3][7:0] st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    st_t  sb [$];

    aes_state_fifo_if #(.ROWS(4), .COLS(4), .DEPTH(4)) bus ();

    aes_state_fifo #(.ROWS(4), .COLS(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic st_t mk(input int base);
        st_t s;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s[r][c] = 8'(base + r * 4 + c);
            end
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Settle combinational outputs, score this cycle's handshakes, then
    // advance to just after the next rising edge.
    task automatic step();
        st_t exp_s;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", bus.out_data, 128'h0);
                n_errors += (bus.out_data === 128'h0) ? 1 : 0;
            end else begin
                exp_s = sb.pop_front();
                chk("pop_data", bus.out_data, exp_s);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back(bus.in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input st_t s);
        bus.in_valid  = 1'b1;
        bus.in_data   = s;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset for two cycles
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_count",     bus.count,     128'd0);
        chk("rst_in_ready",  bus.in_ready,  128'd1);
        chk("rst_out_valid", bus.out_valid, 128'd0);
        chk("rst_out_data",  bus.out_data,  128'h0);

        // Two states in, held, then streamed out
        push(mk(8'h00));
        push(mk(8'h10));
        #1;
        chk("t2_count", bus.count, 128'd2);
        chk("t2_head",  bus.out_data, mk(8'h00));
        drain(2);
        #1;
        chk("t2_count_end", bus.count,     128'd0);
        chk("t2_data_end",  bus.out_data,  128'h0);
        chk("t2_valid_end", bus.out_valid, 128'd0);

        // Fill to full, fifth push held, pop one, fifth accepted
        for (int i = 0; i < 4; i++) begin
            push(mk(8'h20 + i * 16));
        end
        #1;
        chk("t3_full_count", bus.count,    128'd4);
        chk("t3_full_ready", bus.in_ready, 128'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = mk(8'h60);
        bus.out_ready = 1'b1;
        #1;
        chk("t3_no_bypass", bus.in_ready, 128'd0);
        step();
        bus.out_ready = 1'b0;
        #1;
        chk("t3_ready_again", bus.in_ready, 128'd1);
        chk("t3_count_3",     bus.count,    128'd3);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("t3_count_4", bus.count, 128'd4);
        drain(4);
        #1;
        chk("t3_empty", bus.count, 128'd0);

        // Steady push+pop at count=2 across pointer wrap
        push(mk(8'h80));
        push(mk(8'h90));
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = mk(8'hA0 + i * 3);
            bus.out_ready = 1'b1;
            step();
            chk("t4_count", bus.count, 128'd2);
        end
        drain(2);
        #1;
        chk("t4_empty", bus.count, 128'd0);

        // Flush with three entries held and a push offered
        push(mk(8'h31));
        push(mk(8'h42));
        push(mk(8'h53));
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = mk(8'h64);
        #1;
        chk("t5_flush_in_ready",  bus.in_ready,  128'd0);
        chk("t5_flush_out_valid", bus.out_valid, 128'd0);
        step();
        sb.delete();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("t5_count_after", bus.count,    128'd0);
        chk("t5_data_after",  bus.out_data, 128'h0);
        push(mk(8'h70));
        #1;
        chk("t5_s7_head", bus.out_data, mk(8'h70));
        drain(1);

        // Push three, pop all, every slot must be zero
        push(mk(8'hC0));
        push(mk(8'hD0));
        push(mk(8'hE0));
        drain(3);
        #1;
        chk("t6_count", bus.count, 128'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_slot%0d", i), dut.r_mem[i], 128'h0);
        end
        chk("t6_sb_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
